digit_serial_addsub: RTL and testbench
======================================

Name: digit_serial_addsub

Overview:
- Parametrised digit-serial adder/subtractor; successor to the bit-serial adder.
- Processes DIGITWIDTH bits per clock, trading adder width against latency: WORDWIDTH/DIGITWIDTH cycles per operation.
- Adds subtract mode, signed-overflow flag and valid/ready handshakes on both sides, so it can slot into CIC integrator/comb datapaths with backpressure.

Parameters:
WORDWIDTH, 16, operand/result width in bits
DIGITWIDTH, 4, bits processed per cycle; must divide WORDWIDTH exactly (1 = bit-serial, WORDWIDTH = parallel)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  operands and mode valid
in_ready  output  1  block can accept operands
a_in  input  WORDWIDTH  operand A
b_in  input  WORDWIDTH  operand B
sub  input  1  0: A+B, 1: A-B; sampled with operands
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum_out  output  WORDWIDTH  result
cout  output  1  add: carry out; sub: 1 = no borrow (A>=B unsigned)
ovf  output  1  two's-complement signed overflow
busy  output  1  high in RUN or DONE

Behaviour:
- NDIG = WORDWIDTH/DIGITWIDTH. Elaboration error if WORDWIDTH % DIGITWIDTH != 0 or DIGITWIDTH < 1.
- Reset (async, any state): state = IDLE.
  - in_ready = 1; out_valid = 0; busy = 0.
  - sum_out, cout, ovf = 0; internal shift registers, carry and digit counter = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at an edge:
    - Load a_in into shift register A.
    - Load b_in into shift register B; if sub = 1, load ~b_in instead.
    - Carry register = sub.
    - Counter = 0.
    - Go to RUN.
- RUN:
  - in_ready = 0.
  - Each cycle, the digit adder adds the low DIGITWIDTH bits of A and B plus the carry.
  - The sum digit shifts into the result register from the top; A and B shift right by DIGITWIDTH; carry register takes the digit carry-out.
  - Counter increments each cycle.
  - On the edge processing digit NDIG-1:
    - Latch sum_out, cout (final carry) and ovf.
    - ovf = carry into MSB XOR carry out of MSB.
    - Go to DONE.
- DONE:
  - out_valid = 1; sum_out, cout and ovf held stable.
  - On out_ready at an edge, return to IDLE with out_valid = 0.
  - in_ready stays 0 while in DONE; in_valid is ignored.
- Latency: operands accepted at edge 0; out_valid is high after edge NDIG. With out_ready held high, next accept is possible at edge NDIG+2, so the minimum initiation interval is NDIG+2 cycles.
- sum_out, cout and ovf update only on entry to DONE; between operations they keep their last values.
- Arithmetic is modulo 2^WORDWIDTH.
- Subtract is implemented as A + ~B + 1; cout = 0 indicates a borrow.
- NDIG = 1: RUN lasts one cycle.
- Counter width: $clog2(NDIG)+1.
- in_valid is a don't-care outside IDLE.
- Inputs may change freely after acceptance; the block uses only captured copies.
- Reset mid-RUN or mid-DONE aborts the operation; no out_valid is produced for it.

Decomposition:
- Package serial_arith_pkg holds:
  - state enum type (IDLE, RUN, DONE);
  - function computing NDIG and counter width.
- Sub-module digit_adder: combinational DIGITWIDTH-bit adder.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, c_msb (carry into the MSB, used for ovf).
- Operand shift registers are inline; they are a parametrised digit-shift version of the existing serial shift register.

Test Plan:
(WORDWIDTH=16, DIGITWIDTH=4, NDIG=4 unless noted.)
1. Reset, then idle 3 cycles:
   - required: in_ready=1, out_valid=0, busy=0, sum_out=0x0000, cout=0, ovf=0.
2. Add 0x1234+0x0FFF, sub=0:
   - required: out_valid exactly 4 edges after accept; sum_out=0x2233, cout=0, ovf=0.
3. Add 0xFFFF+0x0001:
   - required: sum_out=0x0000, cout=1, ovf=0.
4. Add 0x7FFF+0x0001:
   - required: sum_out=0x8000, cout=0, ovf=1.
5. Subtract, sub=1:
   - 0x0005-0x0007: sum_out=0xFFFE, cout=0, ovf=0.
   - 0x8000-0x0001: sum_out=0x7FFF, cout=1, ovf=1.
6. Backpressure, then reset:
   - Hold out_ready=0 for 6 cycles in DONE and pulse in_valid with new operands:
     - outputs stay stable; in_ready=0; new operands not taken.
     - Release out_ready: back to IDLE next cycle.
   - Then assert rst_n=0 two cycles into RUN:
     - all outputs return to reset values and no out_valid appears.
   - Repeat scenarios 2–5 with DIGITWIDTH=1 (latency 16) and DIGITWIDTH=16 (latency 1): identical results.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared state encoding and sizing helpers for the serial arithmetic blocks.
package serial_arith_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic int ndig(input int w, input int d);
        return w / d;
    endfunction
    function automatic int cnt_width(input int w, input int d);
        return $clog2(w / d) + 1;
    endfunction
endpackage

// File: rtl/digit_serial_addsub_if.sv
// digit_serial_addsub_if: operand/result handshake bundle for the digit-serial adder/subtractor.
interface digit_serial_addsub_if #(parameter int WORDWIDTH = 16);
    logic                 in_valid, in_ready, sub, out_valid, out_ready, cout, ovf, busy;
    logic [WORDWIDTH-1:0] a_in, b_in, sum_out;
    modport master(output in_valid, a_in, b_in, sub, out_ready,
                   input in_ready, out_valid, sum_out, cout, ovf, busy);
    modport slave(input in_valid, a_in, b_in, sub, out_ready,
                  output in_ready, out_valid, sum_out, cout, ovf, busy);
endinterface

// File: rtl/digit_adder.sv
// digit_adder: combinational WIDTH-bit adder exposing carry into the MSB for overflow detection.
module digit_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             c_msb
);
    logic [WIDTH:0] full;
    assign full  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign sum   = full[WIDTH-1:0];
    assign cout  = full[WIDTH];
    // Carry into the top bit falls out of the top bit's sum relation.
    assign c_msb = a[WIDTH-1] ^ b[WIDTH-1] ^ sum[WIDTH-1];
endmodule

// File: rtl/digit_serial_addsub.sv
// digit_serial_addsub: DIGITWIDTH-bit-per-cycle adder/subtractor with valid/ready on both sides.
module digit_serial_addsub
    import serial_arith_pkg::*;
#(
    parameter int WORDWIDTH  = 16,
    parameter int DIGITWIDTH = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    digit_serial_addsub_if.slave bus
);
    if (DIGITWIDTH < 1 || WORDWIDTH % DIGITWIDTH != 0) begin : g_bad_params
        $error("DIGITWIDTH must be >= 1 and divide WORDWIDTH");
    end

    localparam int NDIG = ndig(WORDWIDTH, DIGITWIDTH);
    localparam int CW   = cnt_width(WORDWIDTH, DIGITWIDTH);

    state_t                state_q, state_d;
    logic [WORDWIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic                  carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DIGITWIDTH-1:0] dsum;
    logic                  dcout, dcmsb, last;

    digit_adder #(.WIDTH(DIGITWIDTH)) u_add (
        .a    (a_q[DIGITWIDTH-1:0]),
        .b    (b_q[DIGITWIDTH-1:0]),
        .cin  (carry_q),
        .sum  (dsum),
        .cout (dcout),
        .c_msb(dcmsb)
    );

    assign last          = cnt_q == CW'(NDIG - 1);
    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.busy      = state_q != IDLE;
    assign bus.sum_out   = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                a_d     = bus.a_in;
                b_d     = bus.sub ? ~bus.b_in : bus.b_in;
                carry_d = bus.sub;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                // A doubles as the result register: sum digits enter from the top as operand digits leave.
                a_d     = (a_q >> DIGITWIDTH) | (WORDWIDTH'(dsum) << (WORDWIDTH - DIGITWIDTH));
                b_d     = b_q >> DIGITWIDTH;
                carry_d = dcout;
                cnt_d   = cnt_q + CW'(1);
                if (last) begin
                    sum_d   = a_d;
                    cout_d  = dcout;
                    ovf_d   = dcmsb ^ dcout;
                    state_d = DONE;
                end
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_digit_serial_addsub.sv
// tb_digit_serial_addsub: runs DIGITWIDTH = 4, 1 and 16 lanes side by side against an arithmetic model.
module tb_digit_serial_addsub;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, sub = 1'b0, out_ready = 1'b0;
    logic [15:0] a_in = '0, b_in = '0;
    logic [2:0]  ir, ov, bz, co, of;
    logic [2:0][15:0] so;
    int          pass_cnt = 0, chk_cnt = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_lane
        digit_serial_addsub_if #(.WORDWIDTH(16)) bus ();
        assign bus.in_valid  = in_valid;
        assign bus.a_in      = a_in;
        assign bus.b_in      = b_in;
        assign bus.sub       = sub;
        assign bus.out_ready = out_ready;
        assign ir[g]         = bus.in_ready;
        assign ov[g]         = bus.out_valid;
        assign bz[g]         = bus.busy;
        assign co[g]         = bus.cout;
        assign of[g]         = bus.ovf;
        assign so[g]         = bus.sum_out;
        digit_serial_addsub #(.WORDWIDTH(16), .DIGITWIDTH(g == 0 ? 4 : g == 1 ? 1 : 16)) dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (bus)
        );
    end

    function automatic int lat_exp(input int i);
        return i == 0 ? 4 : i == 1 ? 16 : 1;
    endfunction

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s, input int hold);
        logic [15:0] e_sum;
        logic        e_co, e_of;
        int          r, ua, ub;
        int          lat[3];
        ua    = int'(a);
        ub    = int'(b);
        e_sum = s ? a - b : a + b;
        e_co  = s ? (ua >= ub) : (ua + ub > 65535);
        r     = s ? int'($signed(a)) - int'($signed(b)) : int'($signed(a)) + int'($signed(b));
        e_of  = (r > 32767) || (r < -32768);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk_cnt++;
            if (ir[i] !== 1'b1) $display("FAIL ready_before_accept lane%0d: got %b want 1", i, ir[i]);
            else pass_cnt++;
        end
        in_valid = 1'b1; a_in = a; b_in = b; sub = s; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; a_in = 16'($urandom); b_in = 16'($urandom); sub = 1'($urandom);
        for (int i = 0; i < 3; i++) lat[i] = -1;
        for (int c = 1; c <= 40 && (lat[0] < 0 || lat[1] < 0 || lat[2] < 0); c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) if (lat[i] < 0 && ov[i]) lat[i] = c;
        end
        for (int i = 0; i < 3; i++) begin
            chk_cnt++;
            if (lat[i] != lat_exp(i)) $display("FAIL latency lane%0d: got %0d want %0d", i, lat[i], lat_exp(i));
            else pass_cnt++;
            chk_cnt++;
            if ({so[i], co[i], of[i]} !== {e_sum, e_co, e_of})
                $display("FAIL result lane%0d %h%s%h: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                         i, a, s ? "-" : "+", b, so[i], co[i], of[i], e_sum, e_co, e_of);
            else pass_cnt++;
        end
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1; a_in = 16'($urandom); b_in = 16'($urandom); sub = 1'($urandom);
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                chk_cnt++;
                if ({ov[i], ir[i], so[i], co[i], of[i]} !== {1'b1, 1'b0, e_sum, e_co, e_of})
                    $display("FAIL hold lane%0d: got ov=%b ir=%b sum=%h want ov=1 ir=0 sum=%h", i, ov[i], ir[i], so[i], e_sum);
                else pass_cnt++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_cnt++;
            if ({ov[i], ir[i], bz[i], so[i]} !== {1'b0, 1'b1, 1'b0, e_sum})
                $display("FAIL release lane%0d: got ov=%b ir=%b busy=%b sum=%h want ov=0 ir=1 busy=0 sum=%h",
                         i, ov[i], ir[i], bz[i], so[i], e_sum);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk_cnt++;
            if ({ir[i], ov[i], bz[i], so[i], co[i], of[i]} !== {3'b100, 16'h0000, 2'b00})
                $display("FAIL reset lane%0d: got ir=%b ov=%b busy=%b sum=%h cout=%b ovf=%b want 1 0 0 0000 0 0",
                         i, ir[i], ov[i], bz[i], so[i], co[i], of[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_add();
        run_op(16'h1234, 16'h0FFF, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 0);
    endtask

    task automatic test_sub();
        run_op(16'h0005, 16'h0007, 1'b1, 0);
        run_op(16'h8000, 16'h0001, 1'b1, 0);
        run_op(16'h1234, 16'h1234, 1'b1, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) run_op(16'($urandom), 16'($urandom), 1'($urandom), 0);
    endtask

    task automatic test_backpressure();
        run_op(16'h1234, 16'h0FFF, 1'b0, 6);
    endtask

    task automatic test_reset_mid_run();
        logic [2:0] seen;
        @(negedge clk);
        in_valid = 1'b1; a_in = 16'h1234; b_in = 16'h0FFF; sub = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk_cnt++;
            if ({ir[i], ov[i], bz[i], so[i], co[i], of[i]} !== {3'b100, 16'h0000, 2'b00})
                $display("FAIL reset_mid lane%0d: got ir=%b ov=%b busy=%b sum=%h cout=%b ovf=%b want 1 0 0 0000 0 0",
                         i, ir[i], ov[i], bz[i], so[i], co[i], of[i]);
            else pass_cnt++;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b0;
        seen = '0;
        repeat (20) begin
            @(posedge clk); #1;
            seen = seen | ov;
        end
        for (int i = 0; i < 3; i++) begin
            chk_cnt++;
            if (seen[i] !== 1'b0) $display("FAIL aborted_no_valid lane%0d: got out_valid seen=%b want 0", i, seen[i]);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_random();
        test_backpressure();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end
endmodule
